// File: rtl/par_stream_checker.sv
// par_stream_checker: per-channel parity / all-ones checker over a valid/ready stream,
// either per beat or accumulated across a frame, with a saturating error counter.
module par_stream_checker #(
  parameter int W     = 8,
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter bit ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mode,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [N_CH*W-1:0] i_in_data,
  input  logic              i_in_last,
  input  logic [N_CH-1:0]   i_in_exp_par,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [N_CH-1:0]   o_out_parity,
  output logic [N_CH-1:0]   o_out_all_ones,
  output logic [N_CH-1:0]   o_out_err,
  input  logic              i_clr_count,
  output logic [CNT_W-1:0]  o_err_count
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t r_state, w_next;
  logic r_out_valid;
  logic [N_CH-1:0] r_par, r_ones, r_err, r_acc_par, r_acc_ones;
  logic [CNT_W-1:0] r_cnt;
  logic w_accept, w_open, w_load, w_acc;
  logic [N_CH-1:0] w_bx, w_ba, w_xp, w_par, w_ones, w_err;
  logic [CNT_W:0] w_sum;
  assign o_in_ready = rst_n & (~r_out_valid | i_out_ready);
  assign w_accept = i_in_valid & o_in_ready;
  assign w_open = (r_state == ACCUM);
  // An open frame keeps accumulating regardless of the current mode input.
  assign w_load = w_accept & (~(w_open | i_mode) | i_in_last);
  assign w_acc = w_accept & ~w_load;
  always_comb begin
    w_bx = '0;
    w_ba = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_bx[c] = ^i_in_data[c*W +: W];
      w_ba[c] = &i_in_data[c*W +: W];
    end
  end
  assign w_xp = (w_open ? r_acc_par : '0) ^ w_bx;
  assign w_par = w_xp ^ {N_CH{ODD}};
  assign w_ones = (w_open ? r_acc_ones : '1) & w_ba;
  assign w_err = w_par ^ i_in_exp_par;
  always_comb begin
    w_sum = {1'b0, r_cnt};
    for (int c = 0; c < N_CH; c++) w_sum = w_sum + (CNT_W+1)'(w_err[c]);
  end
  always_comb begin
    w_next = r_state;
    w_next = w_acc ? ACCUM : w_load ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_par       <= '0;
      r_ones      <= '0;
      r_err       <= '0;
      r_acc_par   <= '0;
      r_acc_ones  <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_acc_par  <= w_xp;
        r_acc_ones <= w_ones;
      end
      if (w_load) begin
        r_par       <= w_par;
        r_ones      <= w_ones;
        r_err       <= w_err;
        r_out_valid <= 1'b1;
      end else if (i_out_ready) r_out_valid <= 1'b0;
      r_cnt <= i_clr_count ? '0 : w_load ? (w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0]) : r_cnt;
    end
  end
  assign o_out_valid    = r_out_valid;
  assign o_out_parity   = r_par;
  assign o_out_all_ones = r_ones;
  assign o_out_err      = r_err;
  assign o_err_count    = r_cnt;
endmodule
